// File: rtl/bridge_pkg.sv
// Shared definitions for the Harvard-to-single-bus bridge: FSM state
// encoding, the full-word byte-enable constant and an address helper.
// No ports; imported by harvard_bus_bridge.
package bridge_pkg;

  typedef enum logic [2:0] {
    RESET_HOLD = 3'd0,
    IDLE       = 3'd1,
    IFETCH     = 3'd2,
    DREAD      = 3'd3,
    DWRITE     = 3'd4,
    STEP       = 3'd5,
    HALT       = 3'd6
  } state_e;

  // Every bus access is a full word; the CPU handles partial stores itself.
  localparam logic [3:0] BYTE_EN_ALL = 4'hF;

  // Word-align a byte address (drop the two byte-offset bits).
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/reset_sync.sv
// Reset synchroniser: asserts asynchronously, deasserts after two clk edges.
// Latency: 2 cycles on deassertion, 0 on assertion. No backpressure.
// Ports: clk, rst_async_n (raw active-low reset), rst_sync_n (synchronised).
module reset_sync (
  input  logic clk,
  input  logic rst_async_n,
  output logic rst_sync_n
);

  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], 1'b1};
    end
  end

  assign rst_sync_n = sync_q[1];

endmodule

// File: rtl/harvard_bus_bridge.sv
// Bridges a Harvard CPU (separate instr/data ports) onto one word-wide bus,
// stepping the CPU one clock at a time via cpu_clk_enable.
// Latency: instruction hit with no data access steps the CPU every 2 cycles.
// Backpressure: waitrequest holds the current access (bus outputs frozen),
// clk_enable low freezes FSM, latches and counters.
// Ports: clk/reset/clk_enable; CPU side instr_*, data_*, cpu_*; bus side
// address/read/write/writedata/byteenable out, waitrequest/readdata in.
module harvard_bus_bridge
  import bridge_pkg::*;
#(
  parameter int RST_HOLD = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  // CPU side
  input  logic [31:0] instr_address,
  input  logic [31:0] data_address,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [31:0] data_writedata,
  input  logic        cpu_active,
  output logic [31:0] instr_readdata,
  output logic [31:0] data_readdata,
  output logic        cpu_clk_enable,
  output logic        cpu_reset,
  // Bus side
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata
);

  localparam logic [7:0] HOLD_CNT = 8'(RST_HOLD);

  logic rst_n;

  reset_sync u_reset_sync (
    .clk        (clk),
    .rst_async_n(reset),
    .rst_sync_n (rst_n)
  );

  state_e      state_q,     state_d;
  logic [7:0]  hold_cnt_q,  hold_cnt_d;
  logic [31:0] address_q,   address_d;
  logic        read_q,      read_d;
  logic        write_q,     write_d;
  logic [31:0] writedata_q, writedata_d;
  logic [31:0] instr_dat_q, instr_dat_d;
  logic [31:0] instr_tag_q, instr_tag_d;
  logic        instr_vld_q, instr_vld_d;
  logic [31:0] data_dat_q,  data_dat_d;
  logic        data_vld_q,  data_vld_d;

  // The synchronised reset asserts asynchronously, so a reset mid-transfer
  // drops read/write at once; only its release is delayed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RESET_HOLD;
      hold_cnt_q  <= 8'd0;
      address_q   <= 32'd0;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      writedata_q <= 32'd0;
      instr_dat_q <= 32'd0;
      instr_tag_q <= 32'd0;
      instr_vld_q <= 1'b0;
      data_dat_q  <= 32'd0;
      data_vld_q  <= 1'b0;
    end else if (clk_enable) begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      address_q   <= address_d;
      read_q      <= read_d;
      write_q     <= write_d;
      writedata_q <= writedata_d;
      instr_dat_q <= instr_dat_d;
      instr_tag_q <= instr_tag_d;
      instr_vld_q <= instr_vld_d;
      data_dat_q  <= data_dat_d;
      data_vld_q  <= data_vld_d;
    end
  end

  // Bus strobes are registered and set on entry to an access state, so they
  // line up with state_q and stay put while waitrequest or clk_enable stall.
  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    address_d   = address_q;
    read_d      = read_q;
    write_d     = write_q;
    writedata_d = writedata_q;
    instr_dat_d = instr_dat_q;
    instr_tag_d = instr_tag_q;
    instr_vld_d = instr_vld_q;
    data_dat_d  = data_dat_q;
    data_vld_d  = data_vld_q;

    case (state_q)
      RESET_HOLD: begin
        if (hold_cnt_q == HOLD_CNT) begin
          state_d = IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      IDLE: begin
        if (!cpu_active) begin
          state_d = HALT;
        end else if (!instr_vld_q || (instr_tag_q != instr_address)) begin
          state_d   = IFETCH;
          address_d = word_align(instr_address);
          read_d    = 1'b1;
        end else if (data_read && !data_vld_q) begin
          state_d   = DREAD;
          address_d = word_align(data_address);
          read_d    = 1'b1;
        end else if (data_write) begin
          state_d     = DWRITE;
          address_d   = word_align(data_address);
          write_d     = 1'b1;
          writedata_d = data_writedata;
        end else begin
          state_d = STEP;
        end
      end
      IFETCH: begin
        if (!waitrequest) begin
          state_d     = IDLE;
          read_d      = 1'b0;
          instr_dat_d = readdata;
          instr_tag_d = instr_address;
          instr_vld_d = 1'b1;
        end
      end
      DREAD: begin
        if (!waitrequest) begin
          state_d    = IDLE;
          read_d     = 1'b0;
          data_dat_d = readdata;
          data_vld_d = 1'b1;
        end
      end
      DWRITE: begin
        if (!waitrequest) begin
          state_d = STEP;
          write_d = 1'b0;
        end
      end
      STEP: begin
        // A new CPU cycle may issue a different load, so the data word is stale.
        state_d    = IDLE;
        data_vld_d = 1'b0;
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = RESET_HOLD;
      end
    endcase
  end

  assign cpu_reset      = (state_q == RESET_HOLD);
  assign cpu_clk_enable = ((state_q == RESET_HOLD) || (state_q == STEP)) && clk_enable;
  assign address        = address_q;
  assign read           = read_q;
  assign write          = write_q;
  assign writedata      = writedata_q;
  assign byteenable     = BYTE_EN_ALL;
  assign instr_readdata = instr_dat_q;
  assign data_readdata  = data_dat_q;

endmodule
